// File: rtl/max7219_pkg.sv
// MAX7219 register map and the 16-bit command word shifted in per device.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] addr;
        logic [7:0] data;
    } max7219_word_t;

endpackage

// File: rtl/spi_max7219_receiver_sync_edge.sv
// Two-flop synchronizer plus history flop; edges are taken between stage 2 and history.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    // [0] first sync stage, [1] second sync stage, [2] history
    logic [2:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = {pipe_q[1:0], i_Async};
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) pipe_q <= {3{RST_VAL}};
        else       pipe_q <= pipe_d;
    end

    assign o_Level = pipe_q[1];
    assign o_Rise  = pipe_q[1] & ~pipe_q[2];
    assign o_Fall  = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_max7219_receiver.sv
// Emulates the register file of a DISP_ROWS x DISP_COLUMNS chain of MAX7219s
// by snooping the SPI frame and decoding it on the LOAD rising edge.
module spi_max7219_receiver
    import max7219_pkg::*;
#(
    parameter int DISP_ROWS    = 5,
    parameter int DISP_COLUMNS = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_SPI_MAX7219_Stb,
    input  logic i_SPI_MAX7219_Clk,
    input  logic i_SPI_MAX7219_Din,
    output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] o_Digits,
    output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][3:0]      o_Intensity,
    output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][2:0]      o_ScanLimit,
    output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]      o_DecodeMode,
    output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           o_Shutdown_n,
    output logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           o_DisplayTest,
    output logic o_Frame_Valid,
    output logic o_Frame_Error
);

    localparam int NUM_DEV    = DISP_ROWS * DISP_COLUMNS;
    localparam int FRAME_BITS = 16 * NUM_DEV;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    logic stb_lvl, stb_rise, stb_fall;
    logic clk_rise;
    logic din_lvl;

    sync_edge #(.RST_VAL(1'b1)) u_sync_stb (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MAX7219_Stb),
        .o_Level(stb_lvl), .o_Rise(stb_rise), .o_Fall(stb_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MAX7219_Clk),
        .o_Level(), .o_Rise(clk_rise), .o_Fall()
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_din (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MAX7219_Din),
        .o_Level(din_lvl), .o_Rise(), .o_Fall()
    );

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0] digits_q, digits_d;
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][3:0]      intensity_q, intensity_d;
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][2:0]      scan_q, scan_d;
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0][7:0]      decode_q, decode_d;
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           shdn_n_q, shdn_n_d;
    logic [DISP_ROWS-1:0][DISP_COLUMNS-1:0]           test_q, test_d;
    logic valid_q, valid_d, err_q, err_d;
    max7219_word_t w;
    logic [2:0]    dig_idx;

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        digits_d    = digits_q;
        intensity_d = intensity_q;
        scan_d      = scan_q;
        decode_d    = decode_q;
        shdn_n_d    = shdn_n_q;
        test_d      = test_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        w           = '0;
        dig_idx     = '0;

        if (stb_fall) begin
            cnt_d = '0;
        end else if (clk_rise && !stb_lvl) begin
            shift_d = {shift_q[FRAME_BITS-2:0], din_lvl};
            if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + 1'b1;
        end

        if (stb_rise) begin
            if (cnt_q == CNT_W'(FRAME_BITS)) begin
                valid_d = 1'b1;
                // device 0 sits nearest the initiator, so its word was shifted last
                for (int r = 0; r < DISP_ROWS; r++) begin
                    for (int c = 0; c < DISP_COLUMNS; c++) begin
                        w       = max7219_word_t'(shift_q[16*(r*DISP_COLUMNS+c) +: 16]);
                        dig_idx = 3'(w.addr - 4'd1);
                        case (w.addr)
                            ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                            ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                                digits_d[dig_idx][r][c] = w.data;
                            ADDR_DECODE:    decode_d[r][c]    = w.data;
                            ADDR_INTENSITY: intensity_d[r][c] = w.data[3:0];
                            ADDR_SCANLIMIT: scan_d[r][c]      = w.data[2:0];
                            ADDR_SHUTDOWN:  shdn_n_d[r][c]    = w.data[0];
                            ADDR_TEST:      test_d[r][c]      = w.data[0];
                            default: ;
                        endcase
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            intensity_q <= '0;
            scan_q      <= '0;
            decode_q    <= '0;
            shdn_n_q    <= '0;
            test_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            intensity_q <= intensity_d;
            scan_q      <= scan_d;
            decode_q    <= decode_d;
            shdn_n_q    <= shdn_n_d;
            test_q      <= test_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign o_Digits      = digits_q;
    assign o_Intensity   = intensity_q;
    assign o_ScanLimit   = scan_q;
    assign o_DecodeMode  = decode_q;
    assign o_Shutdown_n  = shdn_n_q;
    assign o_DisplayTest = test_q;
    assign o_Frame_Valid = valid_q;
    assign o_Frame_Error = err_q;

endmodule
